// File: rtl/mp3_fb_pkg.sv
// Shared framebuffer definitions for the MP3 player image memory.
// Imported by both the write-side loader and the VGA display reader.
package mp3_fb_pkg;

    localparam int unsigned FB_ADDR_W = 15;
    localparam int unsigned FB_DATA_W = 16;
    localparam int unsigned FB_IMG_W  = 160;
    localparam int unsigned FB_IMG_H  = 120;

    typedef enum logic [2:0] {
        FB_IDLE    = 3'd0,
        FB_LOAD_HI = 3'd1,
        FB_LOAD_LO = 3'd2,
        FB_WRITE   = 3'd3,
        FB_DONE    = 3'd4
    } fb_load_state_t;

endpackage

// File: rtl/fb_loader.sv
// Framebuffer writer: packs a big-endian byte stream into 16-bit pixel words
// and writes them sequentially into BRAM port A.
module fb_loader
    import mp3_fb_pkg::*;
#(
    parameter int unsigned IMG_W     = FB_IMG_W,
    parameter int unsigned IMG_H     = FB_IMG_H,
    parameter int unsigned ADDR_W    = FB_ADDR_W,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [7:0]           i_byte,
    input  logic                 i_byte_valid,
    output logic                 o_byte_ready,
    output logic [ADDR_W-1:0]    addra,
    output logic [FB_DATA_W-1:0] dina,
    output logic                 wea,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [ADDR_W-1:0]    o_count
);

    // One extra bit so an image filling the whole address space still terminates.
    localparam logic [ADDR_W:0]   N_WORDS = (ADDR_W + 1)'(IMG_W * IMG_H);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

    fb_load_state_t       state_q, state_d;
    logic [ADDR_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]    addra_q, addra_d;
    logic [FB_DATA_W-1:0] dina_q, dina_d;
    logic                 wea_q, wea_d;
    logic [7:0]           hi_q, hi_d;
    logic [ADDR_W:0]      count_inc;
    logic                 byte_fire;

    assign o_byte_ready = ((state_q == FB_LOAD_HI) || (state_q == FB_LOAD_LO)) && !i_abort;
    assign byte_fire    = o_byte_ready && i_byte_valid;
    assign count_inc    = {1'b0, count_q} + {{ADDR_W{1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addra_d = addra_q;
        dina_d  = dina_q;
        wea_d   = 1'b0;
        hi_d    = hi_q;
        case (state_q)
            FB_IDLE: begin
                if (i_start && !i_abort) begin
                    count_d = '0;
                    state_d = FB_LOAD_HI;
                end
            end
            FB_LOAD_HI: begin
                if (byte_fire) begin
                    hi_d    = i_byte;
                    state_d = FB_LOAD_LO;
                end
            end
            FB_LOAD_LO: begin
                // Address, data and strobe are loaded on the same edge so the BRAM sees one coherent write.
                if (byte_fire) begin
                    dina_d  = {hi_q, i_byte};
                    addra_d = BASE + count_q;
                    wea_d   = 1'b1;
                    state_d = FB_WRITE;
                end
            end
            FB_WRITE: begin
                count_d = count_inc[ADDR_W-1:0];
                state_d = (count_inc == N_WORDS) ? FB_DONE : FB_LOAD_HI;
            end
            FB_DONE: begin
                state_d = FB_IDLE;
            end
            default: begin
                state_d = FB_IDLE;
            end
        endcase
        // A write already strobing in WRITE still lands, so the count above keeps it.
        if (i_abort && (state_q != FB_IDLE)) begin
            state_d = FB_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FB_IDLE;
            count_q <= '0;
            addra_q <= '0;
            dina_q  <= '0;
            wea_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addra_q <= addra_d;
            dina_q  <= dina_d;
            wea_q   <= wea_d;
        end
    end

    always_ff @(posedge clk) begin
        hi_q <= hi_d;
    end

    assign addra   = addra_q;
    assign dina    = dina_q;
    assign wea     = wea_q;
    assign o_count = count_q;
    assign o_busy  = (state_q != FB_IDLE);
    assign o_done  = (state_q == FB_DONE);

endmodule

// File: tb/tb_fb_loader.sv
// Directed bench for fb_loader: two 4x2-word instances (base 0 and base 0x4000)
// share one stimulus stream; a memory model records every port-A write.
module tb_fb_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic        i_abort;
    logic [7:0]  i_byte;
    logic        i_byte_valid;

    logic        o_byte_ready0, wea0, o_busy0, o_done0;
    logic [14:0] addra0, o_count0;
    logic [15:0] dina0;
    logic        o_byte_ready1, wea1, o_busy1, o_done1;
    logic [14:0] addra1, o_count1;
    logic [15:0] dina1;

    int vectors = 0;
    int miscompares = 0;

    logic        prod_en = 1'b0;
    logic        throttle = 1'b0;
    int          acc_cnt = 0;
    int          wr0 = 0, wr1 = 0, dn0 = 0, dn1 = 0, dbl = 0;
    logic        prev_wea0 = 1'b0;
    logic [14:0] last0 = '0, last1 = '0;
    logic [14:0] wlog0 [0:255];
    logic [14:0] wlog1 [0:255];
    logic [15:0] mem0 [0:32767];
    logic [15:0] mem1 [0:32767];

    always #5 clk = ~clk;

    fb_loader #(.IMG_W(4), .IMG_H(2), .ADDR_W(15), .BASE_ADDR(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_byte(i_byte), .i_byte_valid(i_byte_valid), .o_byte_ready(o_byte_ready0),
        .addra(addra0), .dina(dina0), .wea(wea0),
        .o_busy(o_busy0), .o_done(o_done0), .o_count(o_count0));

    fb_loader #(.IMG_W(4), .IMG_H(2), .ADDR_W(15), .BASE_ADDR(32'h4000)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_byte(i_byte), .i_byte_valid(i_byte_valid), .o_byte_ready(o_byte_ready1),
        .addra(addra1), .dina(dina1), .wea(wea1),
        .o_busy(o_busy1), .o_done(o_done1), .o_count(o_count1));

    // Producer: the offered byte is always the count of bytes accepted so far.
    always @(negedge clk) begin
        i_byte       = acc_cnt[7:0];
        i_byte_valid = prod_en && (!throttle || ($urandom_range(0, 2) != 0));
    end

    always @(posedge clk) begin
        if (i_byte_valid && o_byte_ready0) acc_cnt <= acc_cnt + 1;
        if (wea0) begin
            mem0[addra0]     <= dina0;
            wlog0[wr0 % 256] <= addra0;
            last0            <= addra0;
            wr0              <= wr0 + 1;
            if (prev_wea0) dbl <= dbl + 1;
        end
        if (wea1) begin
            mem1[addra1]     <= dina1;
            wlog1[wr1 % 256] <= addra1;
            last1            <= addra1;
            wr1              <= wr1 + 1;
        end
        prev_wea0 <= wea0;
        if (o_done0) dn0 <= dn0 + 1;
        if (o_done1) dn1 <= dn1 + 1;
    end

    task automatic pulse_start();
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < bound && !seen; c++) begin
            if (o_done0 === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        vectors++; if (o_busy0 !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", o_busy0); end
        vectors++; if (o_byte_ready0 !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", o_byte_ready0); end
        vectors++; if (wea0 !== 1'b0) begin miscompares++; $display("FAIL reset_wea got %b want 0", wea0); end
        vectors++; if (addra0 !== 15'h0) begin miscompares++; $display("FAIL reset_addra got %h want 0", addra0); end
        vectors++; if (dina0 !== 16'h0) begin miscompares++; $display("FAIL reset_dina got %h want 0", dina0); end
        vectors++; if (o_done0 !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", o_done0); end
        vectors++; if (o_count0 !== 15'h0) begin miscompares++; $display("FAIL reset_count got %0d want 0", o_count0); end
    endtask

    task automatic test_small_image();
        int w0 = wr0, w1 = wr1, d0 = dn0, done_at = 0;
        logic [14:0] cnt_at_done = '0;
        pulse_start();
        for (int c = 1; c <= 40; c++) begin
            if (o_done0 === 1'b1 && done_at == 0) begin done_at = c; cnt_at_done = o_count0; end
            @(negedge clk);
        end
        vectors++; if (done_at != 25) begin miscompares++; $display("FAIL small_done_cycle got %0d want 25", done_at); end
        vectors++; if (cnt_at_done !== 15'd8) begin miscompares++; $display("FAIL small_count got %0d want 8", cnt_at_done); end
        vectors++; if (wr0 - w0 != 8) begin miscompares++; $display("FAIL small_writes got %0d want 8", wr0 - w0); end
        vectors++; if (dn0 - d0 != 1) begin miscompares++; $display("FAIL small_done_pulses got %0d want 1", dn0 - d0); end
        vectors++; if (mem0[0] !== 16'h0001) begin miscompares++; $display("FAIL small_mem0 got %h want 0001", mem0[0]); end
        vectors++; if (mem0[3] !== 16'h0607) begin miscompares++; $display("FAIL small_mem3 got %h want 0607", mem0[3]); end
        vectors++; if (mem0[7] !== 16'h0E0F) begin miscompares++; $display("FAIL small_mem7 got %h want 0e0f", mem0[7]); end
        vectors++; if (dbl != 0) begin miscompares++; $display("FAIL small_double_write got %0d want 0", dbl); end
        vectors++; if (o_busy0 !== 1'b0) begin miscompares++; $display("FAIL small_busy_after got %b want 0", o_busy0); end
        vectors++; if (wlog1[w1 % 256] !== 15'h4000) begin miscompares++; $display("FAIL base_first_addr got %h want 4000", wlog1[w1 % 256]); end
        vectors++; if (last1 !== 15'h4007) begin miscompares++; $display("FAIL base_last_addr got %h want 4007", last1); end
        vectors++; if (mem1[15'h4000] !== 16'h0001) begin miscompares++; $display("FAIL base_mem_first got %h want 0001", mem1[15'h4000]); end
        vectors++; if (mem1[15'h4007] !== 16'h0E0F) begin miscompares++; $display("FAIL base_mem_last got %h want 0e0f", mem1[15'h4007]); end
        vectors++; if (o_count1 !== 15'd8) begin miscompares++; $display("FAIL base_count got %0d want 8", o_count1); end
    endtask

    task automatic test_throttled();
        int base = acc_cnt, w0 = wr0, d0 = dn0, dbl0 = dbl;
        bit seen;
        logic [15:0] want;
        throttle = 1'b1;
        pulse_start();
        wait_done(300, seen);
        throttle = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (!seen) begin miscompares++; $display("FAIL thr_timeout got no done want done"); end
        vectors++; if (wr0 - w0 != 8) begin miscompares++; $display("FAIL thr_writes got %0d want 8", wr0 - w0); end
        vectors++; if (acc_cnt - base != 16) begin miscompares++; $display("FAIL thr_bytes got %0d want 16", acc_cnt - base); end
        vectors++; if (dbl != dbl0) begin miscompares++; $display("FAIL thr_double_write got %0d want 0", dbl - dbl0); end
        vectors++; if (dn0 - d0 != 1) begin miscompares++; $display("FAIL thr_done_pulses got %0d want 1", dn0 - d0); end
        for (int k = 0; k < 8; k++) begin
            want = {8'(base + 2 * k), 8'(base + 2 * k + 1)};
            vectors++; if (mem0[k] !== want) begin miscompares++; $display("FAIL thr_mem%0d got %h want %h", k, mem0[k], want); end
        end
    endtask

    task automatic test_reset_midload();
        int base;
        bit seen;
        pulse_start();
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        vectors++; if (o_byte_ready1 !== 1'b0) begin miscompares++; $display("FAIL rst_ready1 got %b want 0", o_byte_ready1); end
        rst_n = 1'b1;
        @(negedge clk);
        base = acc_cnt;
        pulse_start();
        wait_done(100, seen);
        vectors++; if (!seen) begin miscompares++; $display("FAIL rst_reload_timeout got no done want done"); end
        vectors++; if (o_count0 !== 15'd8) begin miscompares++; $display("FAIL rst_reload_count got %0d want 8", o_count0); end
        vectors++; if (mem0[0] !== {8'(base), 8'(base + 1)}) begin miscompares++; $display("FAIL rst_reload_mem0 got %h want %h", mem0[0], {8'(base), 8'(base + 1)}); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int base = acc_cnt, w0 = wr0, d0 = dn0, a0 = 0;
        bit hit = 1'b0;
        pulse_start();
        for (int c = 0; c < 100 && !hit; c++) begin
            if (o_count0 === 15'd3 && o_byte_ready0 === 1'b1) hit = 1'b1;
            else @(negedge clk);
        end
        i_abort = 1'b1;
        a0 = acc_cnt;
        @(negedge clk);
        i_abort = 1'b0;
        vectors++; if (o_busy0 !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", o_busy0); end
        repeat (5) @(negedge clk);
        vectors++; if (!hit) begin miscompares++; $display("FAIL abort_reach_word3 got no want yes"); end
        vectors++; if (acc_cnt != a0) begin miscompares++; $display("FAIL abort_byte_taken got %0d want 0", acc_cnt - a0); end
        vectors++; if (acc_cnt - base != 6) begin miscompares++; $display("FAIL abort_bytes got %0d want 6", acc_cnt - base); end
        vectors++; if (o_count0 !== 15'd3) begin miscompares++; $display("FAIL abort_count got %0d want 3", o_count0); end
        vectors++; if (wr0 - w0 != 3) begin miscompares++; $display("FAIL abort_writes got %0d want 3", wr0 - w0); end
        vectors++; if (dn0 != d0) begin miscompares++; $display("FAIL abort_done got %0d want 0", dn0 - d0); end
        vectors++; if (last0 !== 15'd2) begin miscompares++; $display("FAIL abort_last_addr got %0d want 2", last0); end
        vectors++; if (mem0[2] !== {8'(base + 4), 8'(base + 5)}) begin miscompares++; $display("FAIL abort_mem2 got %h want %h", mem0[2], {8'(base + 4), 8'(base + 5)}); end
    endtask

    task automatic test_start_controls();
        int w0 = wr0, d0 = dn0, w1;
        bit seen;
        pulse_start();
        repeat (5) @(negedge clk);
        pulse_start();
        wait_done(100, seen);
        @(negedge clk);
        vectors++; if (!seen) begin miscompares++; $display("FAIL busy_start_timeout got no done want done"); end
        vectors++; if (wr0 - w0 != 8) begin miscompares++; $display("FAIL busy_start_writes got %0d want 8", wr0 - w0); end
        vectors++; if (dn0 - d0 != 1) begin miscompares++; $display("FAIL busy_start_done got %0d want 1", dn0 - d0); end
        @(negedge clk); i_start = 1'b1; i_abort = 1'b1;
        @(negedge clk); i_start = 1'b0; i_abort = 1'b0;
        vectors++; if (o_busy0 !== 1'b0) begin miscompares++; $display("FAIL start_abort_busy got %b want 0", o_busy0); end
        vectors++; if (o_byte_ready0 !== 1'b0) begin miscompares++; $display("FAIL start_abort_ready got %b want 0", o_byte_ready0); end
        vectors++; if (o_count0 !== 15'd8) begin miscompares++; $display("FAIL start_abort_count got %0d want 8", o_count0); end
        w1 = wr0;
        pulse_start();
        vectors++; if (o_count0 !== 15'd0) begin miscompares++; $display("FAIL restart_count_clear got %0d want 0", o_count0); end
        vectors++; if (o_busy0 !== 1'b1 || o_byte_ready0 !== 1'b1) begin miscompares++; $display("FAIL restart_busy_ready got %b%b want 11", o_busy0, o_byte_ready0); end
        wait_done(100, seen);
        @(negedge clk);
        vectors++; if (!seen) begin miscompares++; $display("FAIL restart_timeout got no done want done"); end
        vectors++; if (wlog0[w1 % 256] !== 15'd0) begin miscompares++; $display("FAIL restart_first_addr got %0d want 0", wlog0[w1 % 256]); end
    endtask

    initial begin
        rst_n   = 1'b0;
        i_start = 1'b0;
        i_abort = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n   = 1'b1;
        prod_en = 1'b1;
        repeat (2) @(negedge clk);
        test_small_image();
        test_throttled();
        test_reset_midload();
        test_abort();
        test_start_controls();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
